// File: rtl/spad_types_pkg.sv
// Shared scratchpad/DRAM types: request and response records, widths and responder state encoding.
package spad_types_pkg;

  localparam int DRAM_ID_WIDTH   = 4;
  localparam int DRAM_ADDR_WIDTH = 32;
  localparam int DATA_BYTES      = 16;
  // Byte column within one data word; also the number of ignored low address bits
  localparam int COL_IDX_WIDTH   = $clog2(DATA_BYTES);
  localparam int NUM_BYTES_WIDTH = COL_IDX_WIDTH + 1;
  localparam int LAT_CNT_WIDTH   = 4;

  typedef logic [DATA_BYTES*8-1:0]      scpad_data_t;
  typedef logic [DRAM_ID_WIDTH-1:0]     dram_id_t;
  typedef logic [DRAM_ADDR_WIDTH-1:0]   dram_addr_t;
  typedef logic [NUM_BYTES_WIDTH-1:0]   dram_nbytes_t;

  typedef struct packed {
    logic         write;
    dram_id_t     id;
    dram_addr_t   dram_addr;
    dram_nbytes_t num_bytes;
    scpad_data_t  wdata;
  } dram_req_t;

  typedef struct packed {
    logic        complete;
    dram_id_t    id;
    scpad_data_t rdata;
  } dram_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_t;

endpackage

// File: rtl/scpad_dram_responder_if.sv
// Backend <-> DRAM model request/response bundle.
interface scpad_dram_responder_if;
  import spad_types_pkg::*;

  logic      be_dram_req_valid;
  dram_req_t be_dram_req;
  logic      be_dram_stall;
  logic      dram_be_res_valid;
  dram_res_t dram_be_res;

  modport master (
    output be_dram_req_valid,
    output be_dram_req,
    output be_dram_stall,
    input  dram_be_res_valid,
    input  dram_be_res
  );

  modport slave (
    input  be_dram_req_valid,
    input  be_dram_req,
    input  be_dram_stall,
    output dram_be_res_valid,
    output dram_be_res
  );

endinterface

// File: rtl/scpad_dram_req_fifo.sv
// Pending-request queue; the head entry stays in place until its response is consumed.
module scpad_dram_req_fifo
  import spad_types_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_push,
  input  logic        i_pop,
  input  dram_req_t   i_data,
  output dram_req_t   o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  dram_req_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue still accepts when the head leaves on the same edge
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/scpad_dram_responder.sv
// Fixed-latency DRAM model: queues backend requests, serves them in order from a local
// word memory, and holds each response until the backend is not stalling.
module scpad_dram_responder
  import spad_types_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                   CLK,
  input  logic                   nRST,
  scpad_dram_responder_if.slave  bus,
  output logic                   overflow_err,
  output logic                   busy
);

  localparam int QW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(LATENCY);

  resp_state_t              r_state;
  logic [LAT_CNT_WIDTH-1:0] r_cnt;
  logic                     r_res_valid;
  dram_res_t                r_res;
  logic                     r_ovf;
  scpad_data_t              r_mem [MEM_WORDS];

  dram_req_t                w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [QW-1:0]            w_count;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_more;
  logic                     w_fire;
  logic                     w_commit_wr;
  logic                     w_full_word;
  logic [DATA_BYTES-1:0]    w_be;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_unused_addr;

  assign w_pop  = r_res_valid & ~bus.be_dram_stall;
  assign w_push = bus.be_dram_req_valid & (~w_full | w_pop);
  assign w_drop = bus.be_dram_req_valid & w_full & ~w_pop;

  scpad_dram_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.be_dram_req),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Another entry becomes head on the pop edge if one is queued behind or arrives now
  assign w_more = (w_count > QW'(1)) | w_push;
  assign w_fire = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_commit_wr = w_fire & w_head.write;

  assign w_idx = w_head.dram_addr[COL_IDX_WIDTH +: IDX_W];
  assign w_unused_addr = ^{w_head.dram_addr[DRAM_ADDR_WIDTH-1:COL_IDX_WIDTH+IDX_W],
                           w_head.dram_addr[COL_IDX_WIDTH-1:0]};

  assign w_full_word = (w_head.num_bytes == '0) ||
                       (w_head.num_bytes >= NUM_BYTES_WIDTH'(DATA_BYTES));
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_be
    assign w_be[gi] = w_full_word || (NUM_BYTES_WIDTH'(gi) < w_head.num_bytes);
  end

  always_ff @(posedge CLK) begin
    if (w_commit_wr) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_head.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_WAIT;
            r_cnt   <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state        <= ST_RESP;
            r_res_valid    <= 1'b1;
            r_res.complete <= 1'b1;
            r_res.id       <= w_head.id;
            r_res.rdata    <= w_head.write ? '0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - LAT_CNT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          if (w_pop) begin
            r_res_valid <= 1'b0;
            if (w_more) begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dram_be_res_valid = r_res_valid;
  assign bus.dram_be_res       = r_res;
  assign overflow_err          = r_ovf;
  assign busy                  = ~w_empty | r_res_valid;

endmodule

// File: doc/scpad_dram_responder.md
SCPAD_DRAM_RESPONDER -- requirements
Module: scpad_dram_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request capture to response; legal range 1..15.
REQ-002 Parameter FIFO_DEPTH, default 8: pending-request queue entries; power of two.
REQ-003 Parameter MEM_WORDS, default 1024: backing-store size in scpad_data_t words; power of two.
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 be_dram_req_valid  input  1  backend presents a request this cycle; there is no ready signal back to the backend.
REQ-007 be_dram_req  input  dram_req_t  {write, id, dram_addr, num_bytes, wdata}.
REQ-008 be_dram_stall  input  1  backend cannot accept a response this cycle.
REQ-009 dram_be_res_valid  output  1  response valid.
REQ-010 dram_be_res  output  dram_res_t  {complete, id, rdata}.
REQ-011 overflow_err  output  1  sticky: a request was dropped.
REQ-012 busy  output  1  queue non-empty or response pending.

Function
REQ-013 Every cycle with be_dram_req_valid=1 and the queue not full, or full with a pop in the same cycle, enqueues the request.
REQ-014 A valid request arriving with the queue full and no pop that cycle is dropped, and overflow_err sets and stays 1 until reset.
REQ-015 Requests are serviced strictly in arrival order; one request is in service at a time.
REQ-016 Head latency counter loads LATENCY on the edge the entry becomes head and decrements each cycle; the response register loads when it reaches 0.
REQ-017 With an idle block, a request sampled at edge t produces dram_be_res_valid=1 from edge t+LATENCY+1.
REQ-018 The next head loads its counter on the edge that pops the previous response.
REQ-019 Word index = dram_addr[log2(DATA_BYTES) +: log2(MEM_WORDS)]; lower offset bits are ignored; higher bits wrap modulo MEM_WORDS.
REQ-020 Read: rdata = mem[index], complete=1, id echoed.
REQ-021 Write: bytes 0..num_bytes-1 of mem[index] take wdata bytes and the rest are unchanged; num_bytes=0 or num_bytes >= DATA_BYTES writes the full word.
REQ-022 Write response: complete=1, id echoed, rdata=0.
REQ-023 A write commits to memory on the edge its response register loads, so a later read to the same word returns the new data.
REQ-024 dram_be_res_valid and dram_be_res hold stable while be_dram_stall=1; the response pops on an edge with valid=1 and stall=0.
REQ-025 Stall has no effect on request capture.
REQ-026 Queue pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and indices equal; empty = pointers equal.
REQ-027 busy = !empty | dram_be_res_valid.

Reset
REQ-028 nRST low clears queue pointers, head counter, dram_be_res_valid, dram_be_res (all zero), overflow_err and busy, immediately and independent of CLK.
REQ-029 Reset mid-operation discards all pending requests and any held response; no response for them is emitted after reset.
REQ-030 Backing memory contents are not reset.

Structure
REQ-031 dram_req_t and dram_res_t live in spad_types_pkg alongside DRAM_ID_WIDTH, DRAM_ADDR_WIDTH, COL_IDX_WIDTH, DATA_BYTES and scpad_data_t; the scratchpad interface uses the same package types.
REQ-032 The request queue is one sub-module, scpad_dram_req_fifo (push, pop, full, empty, head data).
REQ-033 The latency counter, response register and memory are in the top module.

Verification
REQ-034 Write id=3, addr=0x40, num_bytes=0, wdata=all 0xA5; then read id=4, addr=0x40 -> two responses in order (id3 complete rdata=0, then id4 rdata all 0xA5); with LATENCY=4, the first is valid 5 cycles after capture.
REQ-035 Partial write: write addr=0x40 with num_bytes=2 and wdata bytes 0x11,0x22, then read -> bytes0..1 = 0x11,0x22 and the remaining bytes still 0xA5.
REQ-036 Hold be_dram_stall=1 for 6 cycles while a response is valid -> valid and data are unchanged across all 6 cycles; the response pops on the first cycle with stall=0, and the next response follows LATENCY+1 cycles later.
REQ-037 Send 10 back-to-back reads with FIFO_DEPTH=8 and stall held high -> exactly 2 are dropped (first 8 queued, 1 in service frees one slot only after its pop), overflow_err=1, and responses for the accepted ids come in order.
REQ-038 Address wrap: write addr = MEM_WORDS*DATA_BYTES + 0x40, then read 0x40 -> the read returns the written data.
REQ-039 Assert nRST low with 3 requests queued -> outputs go 0 asynchronously; after release, no stale response appears and the memory retains prior data.
